execute_stage: RTL
==================

Name: execute_stage

Overview:
- Execute (E) stage of the 16-bit pipelined core; consumes the ID/EXE register outputs produced by decode.
- Selects forwarded operands, runs the ALU and resolves branch/jump.
- Registers the result into the EXE/MEM pipeline register that feeds memory and writeback.
- Drives PCSrcE/PCTargetE back to fetch and the hazard logic.

Parameters:
- WIDTH, 16, datapath width
- RW, 4, register-index width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- RD1E  in  WIDTH  operand A from ID/EXE
- RD2E  in  WIDTH  operand B from ID/EXE
- immExtE  in  WIDTH  sign-extended immediate
- PCE  in  WIDTH  target-address field (zero-extended inst[11:0])
- PCPlus2E  in  WIDTH  PC+2 of the instruction
- RdE  in  RW  destination register
- regWriteE, memWriteE, jumpE, branchE, aluSrcE  in  1 each  control from ID/EXE
- aluControlE  in  3  ALU operation
- resultSrcE  in  2  writeback select
- forwardAE, forwardBE  in  2 each  00 = ID/EXE value, 01 = resultWB, 10 = ALUResultM, 11 = ID/EXE value
- resultWB  in  WIDTH  writeback-stage result
- stallM  in  1  hold EXE/MEM register
- flushM  in  1  load bubble into EXE/MEM register
- PCSrcE  out  1  redirect fetch (combinational)
- PCTargetE  out  WIDTH  redirect address (combinational)
- ALUResultM, WriteDataM, PCPlus2M  out  WIDTH  registered
- RdM  out  RW  registered
- regWriteM, memWriteM  out  1  registered
- resultSrcM  out  2  registered
- flagsM  out  3  registered {N, Z, C}

Behaviour:
- Operand selection:
  - srcA = forwardAE mux of RD1E.
  - fwdB = forwardBE mux of RD2E.
  - srcB = aluSrcE ? immExtE : fwdB.
- ALU (combinational, WIDTH bits, results truncated):
  - 000 ADD: C = carry out.
  - 001 SUB: srcA − srcB; C = no-borrow (srcA >= srcB unsigned).
  - 010 AND; 011 OR; 100 XOR.
  - 101 SLL by srcB[3:0]; 110 SRL (logical) by srcB[3:0].
  - 111 PASS srcB.
  - C = 0 for ops 010–111.
  - Z = (result == 0); N = result[WIDTH-1].
- Control resolution:
  - PCSrcE = jumpE | (branchE & Z).
  - PCTargetE = PCE; jump and branch targets are absolute.
  - Both outputs are purely combinational, zero-latency.
- EXE/MEM register: one-cycle latency; on each rising clk edge, in priority order:
  - rst low (async): all registered outputs = 0, flagsM = 000.
  - flushM = 1: bubble. regWriteM = 0, memWriteM = 0, resultSrcM = 00, data fields = 0, RdM = 0. flagsM is held.
  - stallM = 1: all registered outputs hold.
  - otherwise: ALUResultM ← ALU result, WriteDataM ← fwdB (never the immediate), PCPlus2M ← PCPlus2E, RdM ← RdE, control fields ← E controls.
  - flagsM ← {N, Z, C} only when regWriteE | branchE; otherwise hold.
- flushM and stallM both high: flush wins.
- A branch with its comparison operands forwarded from M/WB uses the forwarded values in the same cycle.
- Reset deasserted mid-stream: the first edge after release captures normally; there is no warm-up cycle.
- An X on a control input that is not selected must not propagate into registered control bits.

Decomposition:
- Shared package `core_pkg`:
  - ALU op encodings (ALU_ADD … ALU_PASSB) as localparams or enum.
  - Forward-select encodings (FWD_E, FWD_WB, FWD_M).
  - Flag bit indices.
- One sub-module `alu`: inputs srcA, srcB, aluControl; outputs result, N, Z, C.
- The EXE/MEM register stays inline in execute_stage.

Test Plan:
- Reset: drive rst low mid-run with regWriteE = 1 → all M outputs and flagsM = 0 immediately, without waiting for clk; held through release.
- ALU/flags: RD1E = 16'h0005, immExtE = 16'h0005, aluSrcE = 1, op SUB, regWriteE = 1 → next cycle ALUResultM = 0000, flagsM = {0,1,1}. Then op ADD with FFFF + 0001 → ALUResultM = 0000, C = 1.
- Forwarding: forwardAE = 10 with ALUResultM = 0x0010, forwardBE = 01 with resultWB = 0x0003, op SLL → ALUResultM = 0x0080, WriteDataM = 0x0003.
- Branch: branchE = 1, SUB of equal operands, PCE = 0x0ABC → PCSrcE = 1 and PCTargetE = 0x0ABC in the same cycle. Unequal operands → PCSrcE = 0. jumpE = 1 → PCSrcE = 1 regardless of Z.
- Stall/flush: stallM = 1 for 2 cycles → M outputs frozen. flushM = 1 with stallM = 1 and memWriteE = 1 → memWriteM = 0, regWriteM = 0, flagsM unchanged.

Source files
------------

// File: rtl/core_pkg.sv
// ============================================================================
// Module      : core_pkg
// Description : Shared encodings for the 16-bit pipelined core (ALU ops,
//               forwarding selects, flag bit positions).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_pkg;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_XOR   = 3'b100;
    localparam logic [2:0] ALU_SLL   = 3'b101;
    localparam logic [2:0] ALU_SRL   = 3'b110;
    localparam logic [2:0] ALU_PASSB = 3'b111;

    // 2'b11 is unused and falls back to the ID/EXE value
    localparam logic [1:0] FWD_E  = 2'b00;
    localparam logic [1:0] FWD_WB = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;

endpackage

`default_nettype wire

// File: rtl/alu.sv
// ============================================================================
// Module      : alu
// Description : Combinational WIDTH-bit ALU producing result and N/Z/C flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu
    import core_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic [2:0]       aluControl,
    output logic [WIDTH-1:0] result,
    output logic             N,
    output logic             Z,
    output logic             C
);

    logic [WIDTH:0] w_sum;

    always_comb begin
        w_sum  = '0;
        result = '0;
        C      = 1'b0;
        case (aluControl)
            ALU_ADD: begin
                w_sum  = {1'b0, srcA} + {1'b0, srcB};
                result = w_sum[WIDTH-1:0];
                C      = w_sum[WIDTH];
            end
            ALU_SUB: begin
                // carry is the no-borrow sense, set when srcA >= srcB unsigned
                result = srcA - srcB;
                C      = (srcA >= srcB);
            end
            ALU_AND:   result = srcA & srcB;
            ALU_OR:    result = srcA | srcB;
            ALU_XOR:   result = srcA ^ srcB;
            ALU_SLL:   result = srcA << srcB[3:0];
            ALU_SRL:   result = srcA >> srcB[3:0];
            ALU_PASSB: result = srcB;
            default:   result = '0;
        endcase
    end

    assign Z = (result == '0);
    assign N = result[WIDTH-1];

endmodule

`default_nettype wire

// File: rtl/execute_stage.sv
// ============================================================================
// Module      : execute_stage
// Description : Execute stage: operand forwarding, ALU, branch/jump resolution
//               and the EXE/MEM pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module execute_stage
    import core_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int RW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] RD1E,
    input  logic [WIDTH-1:0] RD2E,
    input  logic [WIDTH-1:0] immExtE,
    input  logic [WIDTH-1:0] PCE,
    input  logic [WIDTH-1:0] PCPlus2E,
    input  logic [RW-1:0]    RdE,
    input  logic             regWriteE,
    input  logic             memWriteE,
    input  logic             jumpE,
    input  logic             branchE,
    input  logic             aluSrcE,
    input  logic [2:0]       aluControlE,
    input  logic [1:0]       resultSrcE,
    input  logic [1:0]       forwardAE,
    input  logic [1:0]       forwardBE,
    input  logic [WIDTH-1:0] resultWB,
    input  logic             stallM,
    input  logic             flushM,
    output logic             PCSrcE,
    output logic [WIDTH-1:0] PCTargetE,
    output logic [WIDTH-1:0] ALUResultM,
    output logic [WIDTH-1:0] WriteDataM,
    output logic [WIDTH-1:0] PCPlus2M,
    output logic [RW-1:0]    RdM,
    output logic             regWriteM,
    output logic             memWriteM,
    output logic [1:0]       resultSrcM,
    output logic [2:0]       flagsM
);

    logic [WIDTH-1:0] w_srca;
    logic [WIDTH-1:0] w_fwdb;
    logic [WIDTH-1:0] w_srcb;
    logic [WIDTH-1:0] w_result;
    logic             w_n;
    logic             w_z;
    logic             w_c;
    logic [2:0]       w_flags;

    // Unknown or reserved selects fall to the ID/EXE value
    always_comb begin
        case (forwardAE)
            FWD_WB:  w_srca = resultWB;
            FWD_M:   w_srca = ALUResultM;
            default: w_srca = RD1E;
        endcase
        case (forwardBE)
            FWD_WB:  w_fwdb = resultWB;
            FWD_M:   w_fwdb = ALUResultM;
            default: w_fwdb = RD2E;
        endcase
    end

    assign w_srcb = aluSrcE ? immExtE : w_fwdb;

    alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .srcA       (w_srca),
        .srcB       (w_srcb),
        .aluControl (aluControlE),
        .result     (w_result),
        .N          (w_n),
        .Z          (w_z),
        .C          (w_c)
    );

    always_comb begin
        w_flags         = 3'b000;
        w_flags[FLAG_N] = w_n;
        w_flags[FLAG_Z] = w_z;
        w_flags[FLAG_C] = w_c;
    end

    // Targets are absolute, so no adder is needed on the redirect path
    assign PCSrcE    = jumpE | (branchE & w_z);
    assign PCTargetE = PCE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ALUResultM <= '0;
            WriteDataM <= '0;
            PCPlus2M   <= '0;
            RdM        <= '0;
            regWriteM  <= 1'b0;
            memWriteM  <= 1'b0;
            resultSrcM <= 2'b00;
            flagsM     <= 3'b000;
        end else if (flushM) begin
            // Bubble keeps the last architectural flags
            ALUResultM <= '0;
            WriteDataM <= '0;
            PCPlus2M   <= '0;
            RdM        <= '0;
            regWriteM  <= 1'b0;
            memWriteM  <= 1'b0;
            resultSrcM <= 2'b00;
        end else if (!stallM) begin
            ALUResultM <= w_result;
            WriteDataM <= w_fwdb;
            PCPlus2M   <= PCPlus2E;
            RdM        <= RdE;
            regWriteM  <= regWriteE;
            memWriteM  <= memWriteE;
            resultSrcM <= resultSrcE;
            if (regWriteE | branchE) begin
                flagsM <= w_flags;
            end
        end
    end

endmodule

`default_nettype wire
